// File: rtl/vx_cache_mshr_mc_pkg.sv
// Shared cache package: MSHR parameter defaults and the error-cause encoding
// used to build the sticky protocol-violation flag.
package vx_cache_mshr_mc_pkg;

  localparam int MSHR_SIZE_DEF       = 8;
  localparam int LINE_ADDR_WIDTH_DEF = 26;
  localparam int DATA_WIDTH_DEF      = 64;
  localparam int WRITEBACK_DEF       = 0;

  // Each cause owns one bit of the error-cause vector.
  typedef enum logic [1:0] {
    ERR_FILL_INVALID     = 2'd0,  // fill names an entry that is not allocated
    ERR_FINALIZE_INVALID = 2'd1,  // finalize names an entry that is not allocated
    ERR_ALLOC_FULL       = 2'd2,  // allocate fired into an occupied slot
    ERR_FILL_BUSY        = 2'd3   // fill offered while a replay is in progress
  } mshr_err_e;

  localparam int ERR_CAUSES = 4;

endpackage

// File: rtl/VX_dp_ram.sv
// Simple dual-port payload RAM: one write port, one read port whose address
// is sampled on the clock edge. A read that collides with a write to the same
// word returns the word's previous contents.
module VX_dp_ram #(
  parameter int DATAW = 64,
  parameter int SIZE  = 8,
  parameter int ADDRW = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             write,
  input  logic [ADDRW-1:0] waddr,
  input  logic [DATAW-1:0] wdata,
  input  logic [ADDRW-1:0] raddr,
  output logic [DATAW-1:0] rdata
);

  logic [DATAW-1:0] mem_q [SIZE];
  logic [DATAW-1:0] rdata_q;

  // Write port plus read-first synchronous read; contents need no reset.
  always_ff @(posedge clk) begin
    if (write) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/VX_priority_encoder.sv
// Lowest-index-wins priority encoder with a valid flag for an all-zero input.
module VX_priority_encoder #(
  parameter int N  = 8,
  parameter int LN = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  data_in,
  output logic [LN-1:0] index,
  output logic          valid_out
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    index     = '0;
    valid_out = |data_in;
    for (int i = N - 1; i >= 0; i--) begin
      index = data_in[i] ? LN'(i) : index;
    end
  end

endmodule

// File: rtl/vx_cache_mshr_mc.sv
// Cache MSHR: tracks outstanding misses, chains same-line requests behind the
// first miss and replays the whole chain once the line has been filled.
module vx_cache_mshr_mc
  import vx_cache_mshr_mc_pkg::*;
#(
  parameter int  MSHR_SIZE       = MSHR_SIZE_DEF,
  parameter int  LINE_ADDR_WIDTH = LINE_ADDR_WIDTH_DEF,
  parameter int  DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int  WRITEBACK       = WRITEBACK_DEF,
  parameter int  ALM_FULL        = MSHR_SIZE - 2,
  localparam int ID_W            = $clog2(MSHR_SIZE),
  localparam int CNT_W           = $clog2(MSHR_SIZE) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fill_valid,
  output logic                       fill_ready,
  input  logic [ID_W-1:0]            fill_id,
  output logic [LINE_ADDR_WIDTH-1:0] fill_addr,
  output logic                       dequeue_valid,
  input  logic                       dequeue_ready,
  output logic [LINE_ADDR_WIDTH-1:0] dequeue_addr,
  output logic                       dequeue_rw,
  output logic [DATA_WIDTH-1:0]      dequeue_data,
  output logic [ID_W-1:0]            dequeue_id,
  input  logic                       allocate_valid,
  output logic                       allocate_ready,
  input  logic [LINE_ADDR_WIDTH-1:0] allocate_addr,
  input  logic                       allocate_rw,
  input  logic [DATA_WIDTH-1:0]      allocate_data,
  output logic [ID_W-1:0]            allocate_id,
  output logic                       allocate_pending,
  output logic [ID_W-1:0]            allocate_previd,
  input  logic                       finalize_valid,
  input  logic                       finalize_is_release,
  input  logic                       finalize_is_pending,
  input  logic [ID_W-1:0]            finalize_id,
  input  logic [ID_W-1:0]            finalize_previd,
  output logic [CNT_W-1:0]           occupancy,
  output logic                       almost_full,
  output logic                       empty,
  output logic                       error
);

  localparam logic [MSHR_SIZE-1:0] ONE_HOT0 = {{(MSHR_SIZE-1){1'b0}}, 1'b1};

  logic [MSHR_SIZE-1:0]       valid_q, valid_d;
  logic [MSHR_SIZE-1:0]       next_q, next_d;
  logic [ID_W-1:0]            next_index_q [MSHR_SIZE];
  logic [LINE_ADDR_WIDTH-1:0] addr_table_q [MSHR_SIZE];
  logic [MSHR_SIZE-1:0]       rw_table_q;
  logic                       dequeue_valid_q, dequeue_valid_d;
  logic [ID_W-1:0]            dequeue_id_q, dequeue_id_d;
  logic                       allocate_ready_q;
  logic [ID_W-1:0]            allocate_id_q;
  logic [CNT_W-1:0]           occupancy_q, occupancy_d;
  logic                       error_q;

  logic                       allocate_fire_s, fill_fire_s, dequeue_fire_s;
  logic                       finalize_rel_s, finalize_pend_s;
  logic [MSHR_SIZE-1:0]       rel_clr_s, deq_clr_s, alloc_set_s, pend_set_s;
  logic [MSHR_SIZE-1:0]       match_s, tail_s;
  logic [ID_W-1:0]            free_idx_s, tail_idx_s;
  logic                       free_any_s, tail_any_s;
  logic [ERR_CAUSES-1:0]      err_cause_s;

  assign allocate_fire_s = allocate_valid && allocate_ready_q;
  assign fill_fire_s     = fill_valid && !dequeue_valid_q;
  assign dequeue_fire_s  = dequeue_valid_q && dequeue_ready;
  assign finalize_rel_s  = finalize_valid && finalize_is_release;
  assign finalize_pend_s = finalize_valid && finalize_is_pending;

  // Per-index set/clear masks; the allocate set is applied last so it wins.
  assign rel_clr_s   = finalize_rel_s  ? (ONE_HOT0 << finalize_id)     : '0;
  assign deq_clr_s   = dequeue_fire_s  ? (ONE_HOT0 << dequeue_id_q)    : '0;
  assign alloc_set_s = allocate_fire_s ? (ONE_HOT0 << allocate_id_q)   : '0;
  assign pend_set_s  = finalize_pend_s ? (ONE_HOT0 << finalize_previd) : '0;
  assign valid_d     = (valid_q & ~rel_clr_s & ~deq_clr_s) | alloc_set_s;
  assign next_d      = (next_q | pend_set_s) & ~alloc_set_s;

  // Same-line lookup; in write-through mode writes never hold a line open.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < MSHR_SIZE; i++) begin
      match_s[i] = valid_q[i] && (addr_table_q[i] == allocate_addr) &&
                   ((WRITEBACK != 0) || !rw_table_q[i]);
    end
  end

  assign tail_s = match_s & ~next_q;

  VX_priority_encoder #(.N(MSHR_SIZE), .LN(ID_W)) u_free_enc (
    .data_in   (~valid_d),
    .index     (free_idx_s),
    .valid_out (free_any_s)
  );

  VX_priority_encoder #(.N(MSHR_SIZE), .LN(ID_W)) u_tail_enc (
    .data_in   (tail_s),
    .index     (tail_idx_s),
    .valid_out (tail_any_s)
  );

  // Replay sequencing: start on fill, then follow the chain link or a link
  // being written in this very cycle, otherwise the replay ends.
  always_comb begin
    dequeue_valid_d = dequeue_valid_q;
    dequeue_id_d    = dequeue_id_q;
    if (fill_fire_s) begin
      dequeue_valid_d = 1'b1;
      dequeue_id_d    = fill_id;
    end else if (dequeue_fire_s) begin
      if (next_q[dequeue_id_q]) begin
        dequeue_id_d = next_index_q[dequeue_id_q];
      end else if (finalize_pend_s && (finalize_previd == dequeue_id_q)) begin
        dequeue_id_d = finalize_id;
      end else begin
        dequeue_valid_d = 1'b0;
      end
    end else begin
      dequeue_valid_d = dequeue_valid_q;
      dequeue_id_d    = dequeue_id_q;
    end
  end

  // Population count of the next valid mask.
  always_comb begin
    occupancy_d = '0;
    for (int i = 0; i < MSHR_SIZE; i++) begin
      occupancy_d = occupancy_d + CNT_W'(valid_d[i]);
    end
  end

  assign err_cause_s[ERR_FILL_INVALID]     = fill_fire_s && !valid_q[fill_id];
  assign err_cause_s[ERR_FINALIZE_INVALID] = finalize_valid && !valid_q[finalize_id];
  assign err_cause_s[ERR_ALLOC_FULL]       = allocate_fire_s && valid_q[allocate_id_q];
  assign err_cause_s[ERR_FILL_BUSY]        = fill_valid && dequeue_valid_q;

  // Control state; reset also aborts any replay in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q          <= '0;
      next_q           <= '0;
      dequeue_valid_q  <= 1'b0;
      dequeue_id_q     <= '0;
      allocate_ready_q <= 1'b0;
      allocate_id_q    <= '0;
      occupancy_q      <= '0;
      error_q          <= 1'b0;
    end else begin
      valid_q          <= valid_d;
      next_q           <= next_d;
      dequeue_valid_q  <= dequeue_valid_d;
      dequeue_id_q     <= dequeue_id_d;
      allocate_ready_q <= free_any_s;
      allocate_id_q    <= free_idx_s;
      occupancy_q      <= occupancy_d;
      error_q          <= error_q | (|err_cause_s);
    end
  end

  // Address/rw table and chain indices; only read behind a valid bit.
  always_ff @(posedge clk) begin
    if (allocate_fire_s) begin
      addr_table_q[allocate_id_q] <= allocate_addr;
      rw_table_q[allocate_id_q]   <= allocate_rw;
    end
    if (finalize_pend_s) begin
      next_index_q[finalize_previd] <= finalize_id;
    end
  end

  VX_dp_ram #(.DATAW(DATA_WIDTH), .SIZE(MSHR_SIZE), .ADDRW(ID_W)) u_payload (
    .clk   (clk),
    .write (allocate_fire_s),
    .waddr (allocate_id_q),
    .wdata (allocate_data),
    .raddr (dequeue_id_d),
    .rdata (dequeue_data)
  );

  assign fill_ready       = !dequeue_valid_q;
  assign fill_addr        = addr_table_q[fill_id];
  assign dequeue_valid    = dequeue_valid_q;
  assign dequeue_id       = dequeue_id_q;
  assign dequeue_addr     = addr_table_q[dequeue_id_q];
  assign dequeue_rw       = rw_table_q[dequeue_id_q];
  assign allocate_ready   = allocate_ready_q;
  assign allocate_id      = allocate_id_q;
  assign allocate_pending = |match_s;
  assign allocate_previd  = tail_any_s ? tail_idx_s : '0;
  assign occupancy        = occupancy_q;
  assign almost_full      = (occupancy_q >= CNT_W'(ALM_FULL));
  assign empty            = (occupancy_q == '0);
  assign error            = error_q;

endmodule

// File: doc/vx_cache_mshr_mc.md
VX_CACHE_MSHR_MC -- requirements
Module: VX_cache_mshr_mc

Interface
REQ-001 SHALL have parameter MSHR_SIZE, default 8, number of entries (power of two, 2..64).
REQ-002 SHALL have parameter LINE_ADDR_WIDTH, default 26, line-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, per-entry payload width.
REQ-004 SHALL have parameter WRITEBACK, default 0; 0 means write-through, so writes are excluded from pending detection.
REQ-005 SHALL have parameter ALM_FULL, default MSHR_SIZE-2, occupancy threshold for almost_full.
REQ-006 SHALL have derived ID_W = log2(MSHR_SIZE) and CNT_W = log2(MSHR_SIZE)+1.
REQ-007 SHALL have ports `clk in 1`, clock, and `reset in 1`, synchronous, active-high.
REQ-008 SHALL have fill ports `fill_valid in 1`, `fill_ready out 1`, `fill_id in ID_W` and `fill_addr out LINE_ADDR_WIDTH`.
REQ-009 SHALL have dequeue ports `dequeue_valid out 1`, `dequeue_ready in 1`, `dequeue_addr out LINE_ADDR_WIDTH`, `dequeue_rw out 1`, `dequeue_data out DATA_WIDTH` and `dequeue_id out ID_W`.
REQ-010 SHALL have allocate ports `allocate_valid in 1`, `allocate_ready out 1`, `allocate_addr in LINE_ADDR_WIDTH`, `allocate_rw in 1`, `allocate_data in DATA_WIDTH`, `allocate_id out ID_W`, `allocate_pending out 1` and `allocate_previd out ID_W`.
REQ-011 SHALL have finalize ports `finalize_valid in 1`, `finalize_is_release in 1`, `finalize_is_pending in 1`, `finalize_id in ID_W` and `finalize_previd in ID_W`.
REQ-012 SHALL have status ports `occupancy out CNT_W`, `almost_full out 1`, `empty out 1` and `error out 1`, where error is a sticky protocol-violation flag.

Function
REQ-013 Allocate: allocate_ready and allocate_id SHALL be registered from the next-state free mask, selecting the lowest free index; a fire sets the entry valid, stores addr/rw/data and clears its next link.
REQ-014 allocate_pending SHALL be combinational: OR over valid entries whose addr equals allocate_addr; when WRITEBACK=0, write entries are excluded.
REQ-015 allocate_previd SHALL be the lowest-index matching valid entry whose next link is clear, i.e. the chain tail.
REQ-016 Finalize with is_release SHALL clear the valid bit of finalize_id.
REQ-017 Finalize with is_pending SHALL set next[finalize_previd] and record next_index[finalize_previd]=finalize_id.
REQ-018 Both finalize actions SHALL be applied in the same cycle when both flags are set.
REQ-019 Fill handshake: fill_ready SHALL equal ~dequeue_valid.
REQ-020 A fill fire SHALL assert dequeue_valid on the next cycle with dequeue_id=fill_id; fill_addr SHALL be combinational from fill_id.
REQ-021 Dequeue SHALL be a valid/ready handshake; dequeue_valid, id, addr, rw and data SHALL be held stable while ready is low.
REQ-022 On a dequeue fire the entry SHALL be freed, and the next dequeue_id SHALL be chosen in this order:
- next_index when the next link is set;
- finalize_id when a same-cycle finalize_is_pending has previd equal to dequeue_id;
- otherwise dequeue_valid deasserts.
REQ-023 dequeue_data SHALL come from a 1-cycle-read payload RAM (read-during-write returns old data) and SHALL be valid whenever dequeue_valid=1.
REQ-024 occupancy SHALL be a registered popcount of the valid mask.
REQ-025 empty SHALL equal (occupancy==0), and almost_full SHALL equal (occupancy>=ALM_FULL).
REQ-026 occupancy SHALL never exceed MSHR_SIZE or wrap below 0.
REQ-027 error SHALL set, and stay set until reset, on any of:
- fill to an invalid entry;
- finalize to an invalid entry;
- allocate fire when no slot is free;
- fill_valid while fill_ready=0.
REQ-028 When a release, a dequeue and an allocate fire in the same cycle, the allocate valid-set SHALL take priority over clears on the same index.
REQ-029 The valid mask SHALL reflect every same-cycle event on the next cycle.
REQ-030 When the MSHR is full, allocate_ready SHALL be 0; it SHALL return to 1 on the cycle after any free occurs.

Reset
REQ-031 Reset SHALL clear the valid mask, next links, dequeue_valid and error.
REQ-032 After reset, occupancy SHALL be 0, empty SHALL be 1, almost_full SHALL be 0 and fill_ready SHALL be 1.
REQ-033 allocate_ready SHALL be 0 during reset and 1 on the first cycle after it.
REQ-034 A reset asserted mid-replay SHALL abort the chain; the payload RAM and address table SHALL need no reset.

Structure
REQ-035 The MSHR parameter defaults and the error-cause enumeration SHALL live in the shared cache package.
REQ-036 The payload store SHALL be one sub-module, VX_dp_ram, with registered read address.
REQ-037 Lowest-index selection SHALL reuse VX_priority_encoder, with two instances.

Verification
REQ-038 Allocate 8 distinct addresses with MSHR_SIZE=8 -> ids 0..7 in order; occupancy reaches 8; allocate_ready=0; almost_full=1 from occupancy 6.
REQ-039 Allocate addr 0x40 three times (ids 0,1,2) with finalize links 0->1->2, then fill id 0 -> dequeue ids 0,1,2 on consecutive ready cycles with matching data; dequeue_valid=0 afterwards; empty=1.
REQ-040 During a replay at id 1, finalize_is_pending with previd=1 and id=3 in the same cycle -> dequeue continues to id 3.
REQ-041 dequeue_ready held low for 5 cycles -> all dequeue outputs stable; fill_ready=0 throughout.
REQ-042 Write-through mode: write to 0x80, then read to 0x80 -> allocate_pending=0; with WRITEBACK=1 -> allocate_pending=1.
REQ-043 Fill to a free id 5 -> error=1 next cycle and stays set; after reset, error=0 and occupancy=0.
